// File: rtl/hazard_ctrl.sv
// Hazard and redirect control for the EX stage: load-use stalls, branch/jump squashes,
// memory-indirect jump sequencing, and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned MEM_JUMP_WAIT = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       rs_id,
    input  logic [5:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             memRead_ex,
    input  logic             regWrt_ex,
    input  logic [5:0]       rd_ex,
    input  logic             branchZero_ex,
    input  logic             branchNeg_ex,
    input  logic             jump_ex,
    input  logic             jumpMem_ex,
    input  logic             z_flag,
    input  logic             n_flag,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        MEMJ
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_JUMP_WAIT);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect_ex;
    logic load_use;
    logic stall_evt;
    logic flush_evt;

    always_comb begin
        redirect_ex = jump_ex | (branchZero_ex & z_flag) | (branchNeg_ex & n_flag);
        load_use    = memRead_ex & regWrt_ex &
                      ((uses_rs_id & (rs_id == rd_ex)) | (uses_rt_id & (rt_id == rd_ex)));
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        pc_sel      = 2'b00;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;

        // Reset masks every control output; the register block does the clearing.
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (jumpMem_ex) begin
                        stall_pc    = 1'b1;
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        wait_d      = WAIT_INIT;
                        state_d     = MEMJ;
                        flush_evt   = 1'b1;
                    end else if (redirect_ex) begin
                        pc_sel      = 2'b01;
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        flush_evt   = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        stall_evt   = 1'b1;
                    end
                end
                MEMJ: begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    wait_d      = wait_q - 4'd1;
                    if (wait_q > 4'd1) begin
                        stall_pc = 1'b1;
                    end else begin
                        pc_sel  = 2'b10;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_JUMP_WAIT=3, CNT_W=4.
module tb_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic [5:0] rs_id, rt_id, rd_ex;
    logic       uses_rs_id, uses_rt_id, memRead_ex, regWrt_ex;
    logic       branchZero_ex, branchNeg_ex, jump_ex, jumpMem_ex, z_flag, n_flag;
    logic       stall_pc, stall_ifid, flush_ifid, bubble_idex;
    logic [1:0] pc_sel;
    logic [3:0] stall_cnt, flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected output vector layout: {stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_sel}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110100;
    localparam logic [5:0] O_REDIR = 6'b001101;
    localparam logic [5:0] O_MJ    = 6'b101100;
    localparam logic [5:0] O_MJLD  = 6'b001110;

    hazard_ctrl #(
        .MEM_JUMP_WAIT(3),
        .CNT_W        (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .uses_rs_id   (uses_rs_id),
        .uses_rt_id   (uses_rt_id),
        .memRead_ex   (memRead_ex),
        .regWrt_ex    (regWrt_ex),
        .rd_ex        (rd_ex),
        .branchZero_ex(branchZero_ex),
        .branchNeg_ex (branchNeg_ex),
        .jump_ex      (jump_ex),
        .jumpMem_ex   (jumpMem_ex),
        .z_flag       (z_flag),
        .n_flag       (n_flag),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .pc_sel       (pc_sel),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_sel};
    endfunction

    task automatic clear_inputs();
        rs_id = '0; rt_id = '0; rd_ex = '0;
        uses_rs_id = 1'b0; uses_rt_id = 1'b0; memRead_ex = 1'b0; regWrt_ex = 1'b0;
        branchZero_ex = 1'b0; branchNeg_ex = 1'b0; jump_ex = 1'b0; jumpMem_ex = 1'b0;
        z_flag = 1'b0; n_flag = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_load_use(input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt,
                                input logic urs, input logic urt);
        clear_inputs();
        memRead_ex = 1'b1; regWrt_ex = 1'b1; rd_ex = rd;
        rs_id = rs; rt_id = rt; uses_rs_id = urs; uses_rt_id = urt;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        jump_ex = 1'b1; jumpMem_ex = 1'b1;
        #1;
        check_eq("reset_outs_masked", 32'(outs()), 32'(O_IDLE));
        step();
        step();
        check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        clear_inputs();
        reset = 1'b0;
        #1;
        check_eq("idle_outs", 32'(outs()), 32'(O_IDLE));

        // Load-use on rs
        set_load_use(6'd5, 6'd5, 6'd9, 1'b1, 1'b0);
        #1;
        check_eq("lu_rs_outs", 32'(outs()), 32'(O_LU));
        step();
        check_eq("lu_rs_cnt", 32'(stall_cnt), 32'd1);
        clear_inputs();
        #1;
        check_eq("lu_release_outs", 32'(outs()), 32'(O_IDLE));
        step();
        check_eq("lu_release_cnt", 32'(stall_cnt), 32'd1);

        // Matching register but not read
        set_load_use(6'd5, 6'd5, 6'd9, 1'b0, 1'b0);
        #1;
        check_eq("lu_unused_outs", 32'(outs()), 32'(O_IDLE));
        step();
        check_eq("lu_unused_cnt", 32'(stall_cnt), 32'd1);

        // Load-use on rt, and on register 0
        set_load_use(6'd63, 6'd1, 6'd63, 1'b1, 1'b1);
        #1;
        check_eq("lu_rt_outs", 32'(outs()), 32'(O_LU));
        step();
        set_load_use(6'd0, 6'd0, 6'd7, 1'b1, 1'b0);
        #1;
        check_eq("lu_r0_outs", 32'(outs()), 32'(O_LU));
        step();
        check_eq("lu_r0_cnt", 32'(stall_cnt), 32'd3);

        // Load but no register write: no hazard
        set_load_use(6'd5, 6'd5, 6'd5, 1'b1, 1'b1);
        regWrt_ex = 1'b0;
        #1;
        check_eq("lu_nowrite_outs", 32'(outs()), 32'(O_IDLE));
        step();

        // Branches
        clear_inputs();
        branchZero_ex = 1'b1; z_flag = 1'b1;
        #1;
        check_eq("bz_taken_outs", 32'(outs()), 32'(O_REDIR));
        step();
        check_eq("bz_taken_cnt", 32'(flush_cnt), 32'd1);
        z_flag = 1'b0; n_flag = 1'b1;
        #1;
        check_eq("bz_not_taken_outs", 32'(outs()), 32'(O_IDLE));
        step();
        check_eq("bz_not_taken_cnt", 32'(flush_cnt), 32'd1);
        clear_inputs();
        branchNeg_ex = 1'b1; n_flag = 1'b1;
        #1;
        check_eq("bn_taken_outs", 32'(outs()), 32'(O_REDIR));
        step();

        // Redirect wins over a simultaneous load-use
        set_load_use(6'd5, 6'd5, 6'd0, 1'b1, 1'b0);
        jump_ex = 1'b1;
        #1;
        check_eq("jump_lu_outs", 32'(outs()), 32'(O_REDIR));
        step();
        check_eq("jump_lu_flush_cnt", 32'(flush_cnt), 32'd3);
        check_eq("jump_lu_stall_cnt", 32'(stall_cnt), 32'd3);

        // Memory-indirect jump, EX inputs garbage during MEMJ must be ignored
        clear_inputs();
        jumpMem_ex = 1'b1;
        #1;
        check_eq("mj_T_outs", 32'(outs()), 32'(O_MJ));
        step();
        set_load_use(6'd5, 6'd5, 6'd0, 1'b1, 1'b0);
        jump_ex = 1'b1; jumpMem_ex = 1'b1;
        #1;
        check_eq("mj_T1_outs", 32'(outs()), 32'(O_MJ));
        check_eq("mj_T1_flush_cnt", 32'(flush_cnt), 32'd4);
        step();
        check_eq("mj_T2_outs", 32'(outs()), 32'(O_MJ));
        step();
        check_eq("mj_T3_outs", 32'(outs()), 32'(O_MJLD));
        step();
        clear_inputs();
        #1;
        check_eq("mj_T4_outs", 32'(outs()), 32'(O_IDLE));
        check_eq("mj_flush_cnt", 32'(flush_cnt), 32'd4);
        check_eq("mj_stall_cnt", 32'(stall_cnt), 32'd3);
        // Back in RUN: a new redirect is honoured
        jump_ex = 1'b1;
        #1;
        check_eq("mj_T4_run_outs", 32'(outs()), 32'(O_REDIR));
        step();
        clear_inputs();

        // Reset in the middle of MEMJ
        jumpMem_ex = 1'b1;
        #1;
        check_eq("mjr_T_outs", 32'(outs()), 32'(O_MJ));
        step();
        clear_inputs();
        reset = 1'b1;
        #1;
        check_eq("mjr_T1_outs", 32'(outs()), 32'(O_IDLE));
        step();
        reset = 1'b0;
        #1;
        check_eq("mjr_T2_outs", 32'(outs()), 32'(O_IDLE));
        check_eq("mjr_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("mjr_flush_cnt", 32'(flush_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("mjr_no_pcsel10", 32'(outs()), 32'(O_IDLE));
        end

        // Saturation of the stall counter
        for (int i = 1; i <= 20; i++) begin
            set_load_use(6'd12, 6'd3, 6'd12, 1'b0, 1'b1);
            step();
            check_eq("sat_stall_cnt", 32'(stall_cnt), (i > 15) ? 32'd15 : 32'(i));
            clear_inputs();
        end
        check_eq("sat_flush_cnt", 32'(flush_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
